// File: rtl/dram_cmd_sequencer.sv
// ----------------------------------------------------------------------------
// dram_cmd_sequencer
//
// Closed-page DDR5 command sequencer sitting between the request queue and
// the DIMM command bus. Accepts one request at a time, decodes the address
// into channel / bank group / bank / row / column, then issues the two-cycle
// ACT, the two-cycle RD or WR, and a PRE, spacing them by the DRAM timing
// parameters. One DIMM cycle equals two clk cycles, so each parameter costs
// 2*param clk cycles.
//
// Ports
//   clk          CPU clock, rising edge
//   rst          synchronous active-high reset
//   req_valid    request present at queue head
//   req_ready    sequencer idle; request taken when req_valid && req_ready
//   req_op       0=read, 1=write, 2=instruction fetch (read), 3=illegal
//   req_addr     36-bit physical address
//   cmd_valid    one-cycle strobe per command
//   cmd_type     0=ACT0 1=ACT1 2=RD0 3=RD1 4=WR0 5=WR1 6=PRE
//   cmd_channel  addr[6]
//   cmd_bg       addr[9:7]
//   cmd_bank     addr[11:10]
//   cmd_row      addr[33:18]
//   cmd_col      {addr[17:12], addr[5:2]}
//   busy         sequencer not idle
//   done         one-cycle pulse when tRP expires and the sequencer idles
//   err          one-cycle pulse after an illegal op is accepted
// ----------------------------------------------------------------------------
module dram_cmd_sequencer #(
    parameter int unsigned TRCD   = 39,
    parameter int unsigned TCAS   = 40,
    parameter int unsigned TCWL   = 38,
    parameter int unsigned TBURST = 8,
    parameter int unsigned TWR    = 30,
    parameter int unsigned TRP    = 39,
    parameter int unsigned CNT_W  = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_op,
    input  logic [35:0] req_addr,
    output logic        cmd_valid,
    output logic [2:0]  cmd_type,
    output logic        cmd_channel,
    output logic [2:0]  cmd_bg,
    output logic [1:0]  cmd_bank,
    output logic [15:0] cmd_row,
    output logic [9:0]  cmd_col,
    output logic        busy,
    output logic        done,
    output logic        err
);

    // Gap, in clk cycles, from one command strobe to the next.
    localparam int unsigned GAP_RCD = 2 * TRCD;
    localparam int unsigned GAP_RD  = 2 * (TCAS + TBURST);
    localparam int unsigned GAP_WR  = 2 * (TCWL + TBURST + TWR);
    localparam int unsigned GAP_RP  = 2 * TRP;

    // Every gap is at least 2, so each command state can always hand off to
    // its wait state before the counter reaches 1.
    if (CNT_W < 2 || CNT_W > 31 || TRCD < 1 || TRP < 1 || (TCAS + TBURST) < 1 ||
        GAP_WR  >= (32'd1 << CNT_W) || GAP_RD >= (32'd1 << CNT_W) ||
        GAP_RCD >= (32'd1 << CNT_W) || GAP_RP >= (32'd1 << CNT_W)) begin : g_bad_params
        $error("dram_cmd_sequencer: CNT_W too narrow or timing parameter zero");
    end

    localparam logic [CNT_W-1:0] LD_TWO = CNT_W'(2);
    localparam logic [CNT_W-1:0] LD_RCD = CNT_W'(GAP_RCD);
    localparam logic [CNT_W-1:0] LD_RD  = CNT_W'(GAP_RD);
    localparam logic [CNT_W-1:0] LD_WR  = CNT_W'(GAP_WR);
    localparam logic [CNT_W-1:0] LD_RP  = CNT_W'(GAP_RP);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    localparam logic [2:0] CMD_ACT0 = 3'd0;
    localparam logic [2:0] CMD_ACT1 = 3'd1;
    localparam logic [2:0] CMD_RD0  = 3'd2;
    localparam logic [2:0] CMD_RD1  = 3'd3;
    localparam logic [2:0] CMD_WR0  = 3'd4;
    localparam logic [2:0] CMD_WR1  = 3'd5;
    localparam logic [2:0] CMD_PRE  = 3'd6;

    typedef enum logic [3:0] {
        IDLE,
        ACT0,
        ACT1,
        WAIT_RCD,
        CAS0,
        CAS1,
        WAIT_PRE,
        PRE,
        WAIT_RP
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             is_write;

    // Address bits not used by the command fields.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{req_addr[35:34], req_addr[1:0]};

    assign req_ready = (state == IDLE) && !rst;
    assign busy      = (state != IDLE);

    // Each command state is entered with the strobe already registered and
    // the counter loaded with the gap to the next command; the next command
    // fires on the cycle after the counter reads 1.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            is_write    <= 1'b0;
            cmd_valid   <= 1'b0;
            cmd_type    <= '0;
            cmd_channel <= 1'b0;
            cmd_bg      <= '0;
            cmd_bank    <= '0;
            cmd_row     <= '0;
            cmd_col     <= '0;
            done        <= 1'b0;
            err         <= 1'b0;
        end else begin
            cmd_valid <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;

            case (state)
                IDLE: begin
                    if (req_valid) begin
                        if (req_op == 2'd3) begin
                            err <= 1'b1;
                        end else begin
                            state       <= ACT0;
                            cnt         <= LD_TWO;
                            is_write    <= (req_op == 2'd1);
                            cmd_valid   <= 1'b1;
                            cmd_type    <= CMD_ACT0;
                            cmd_channel <= req_addr[6];
                            cmd_bg      <= req_addr[9:7];
                            cmd_bank    <= req_addr[11:10];
                            cmd_row     <= req_addr[33:18];
                            cmd_col     <= {req_addr[17:12], req_addr[5:2]};
                        end
                    end
                end

                ACT0: begin
                    if (cnt == CNT_ONE) begin
                        state     <= ACT1;
                        cnt       <= LD_RCD;
                        cmd_valid <= 1'b1;
                        cmd_type  <= CMD_ACT1;
                    end else begin
                        cnt <= cnt - CNT_ONE;
                    end
                end

                ACT1: begin
                    state <= WAIT_RCD;
                    cnt   <= cnt - CNT_ONE;
                end

                WAIT_RCD: begin
                    if (cnt == CNT_ONE) begin
                        state     <= CAS0;
                        cnt       <= LD_TWO;
                        cmd_valid <= 1'b1;
                        cmd_type  <= is_write ? CMD_WR0 : CMD_RD0;
                    end else begin
                        cnt <= cnt - CNT_ONE;
                    end
                end

                CAS0: begin
                    if (cnt == CNT_ONE) begin
                        state     <= CAS1;
                        cnt       <= is_write ? LD_WR : LD_RD;
                        cmd_valid <= 1'b1;
                        cmd_type  <= is_write ? CMD_WR1 : CMD_RD1;
                    end else begin
                        cnt <= cnt - CNT_ONE;
                    end
                end

                CAS1: begin
                    state <= WAIT_PRE;
                    cnt   <= cnt - CNT_ONE;
                end

                WAIT_PRE: begin
                    if (cnt == CNT_ONE) begin
                        state     <= PRE;
                        cnt       <= LD_RP;
                        cmd_valid <= 1'b1;
                        cmd_type  <= CMD_PRE;
                    end else begin
                        cnt <= cnt - CNT_ONE;
                    end
                end

                PRE: begin
                    state <= WAIT_RP;
                    cnt   <= cnt - CNT_ONE;
                end

                WAIT_RP: begin
                    if (cnt == CNT_ONE) begin
                        state       <= IDLE;
                        cnt         <= '0;
                        is_write    <= 1'b0;
                        done        <= 1'b1;
                        cmd_type    <= '0;
                        cmd_channel <= 1'b0;
                        cmd_bg      <= '0;
                        cmd_bank    <= '0;
                        cmd_row     <= '0;
                        cmd_col     <= '0;
                    end else begin
                        cnt <= cnt - CNT_ONE;
                    end
                end

                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dram_cmd_sequencer.sv
// ----------------------------------------------------------------------------
// tb_dram_cmd_sequencer
//
// Directed bench for dram_cmd_sequencer. The driver pushes the expected
// command/done/err events (cycle + field values) into a queue at acceptance;
// a negedge monitor pops and compares whenever the DUT strobes an output.
// ----------------------------------------------------------------------------
module tb_dram_cmd_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [1:0]  req_op = '0;
    logic [35:0] req_addr = '0;
    logic        cmd_valid;
    logic [2:0]  cmd_type;
    logic        cmd_channel;
    logic [2:0]  cmd_bg;
    logic [1:0]  cmd_bank;
    logic [15:0] cmd_row;
    logic [9:0]  cmd_col;
    logic        busy;
    logic        done;
    logic        err;

    dram_cmd_sequencer #(
        .TRCD(39), .TCAS(40), .TCWL(38), .TBURST(8), .TWR(30), .TRP(39), .CNT_W(16)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_addr(req_addr),
        .cmd_valid(cmd_valid), .cmd_type(cmd_type),
        .cmd_channel(cmd_channel), .cmd_bg(cmd_bg), .cmd_bank(cmd_bank),
        .cmd_row(cmd_row), .cmd_col(cmd_col),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vectors = 0;
    int miscompares = 0;

    // {kind, type, ch, bg, bank, row, col, busy, ready}; kind 0=cmd 1=done 2=err 3=several
    typedef struct {
        int unsigned cyc;
        logic [38:0] sig;
    } exp_t;

    exp_t exp_q[$];

    function automatic logic [38:0] pack(input logic [1:0] k, input logic [2:0] t,
                                         input logic ch, input logic [2:0] bg,
                                         input logic [1:0] bank, input logic [15:0] row,
                                         input logic [9:0] col, input logic bz,
                                         input logic rdy);
        return {k, t, ch, bg, bank, row, col, bz, rdy};
    endfunction

    task automatic push_ev(input int unsigned c, input logic [38:0] s);
        exp_t e;
        e.cyc = c;
        e.sig = s;
        exp_q.push_back(e);
    endtask

    task automatic chk(input string nm, input logic [39:0] act, input logic [39:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: actual=%h required=%h at cycle %0d", nm, act, req, cyc);
        end
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        if (cmd_valid || done || err) begin
            logic [1:0]  k;
            logic [38:0] act;
            exp_t        e;
            if (32'(cmd_valid) + 32'(done) + 32'(err) > 1) k = 2'd3;
            else if (cmd_valid)                          k = 2'd0;
            else if (done)                               k = 2'd1;
            else                                         k = 2'd2;
            act = pack(k, cmd_type, cmd_channel, cmd_bg, cmd_bank, cmd_row, cmd_col,
                       busy, req_ready);
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_event: actual=%h required=none at cycle %0d", act, cyc);
            end else begin
                e = exp_q.pop_front();
                if (cyc != e.cyc) begin
                    miscompares++;
                    $display("FAIL event_cycle: actual=%0d required=%0d", cyc, e.cyc);
                end
                vectors++;
                if (act !== e.sig) begin
                    miscompares++;
                    $display("FAIL event_fields: actual=%h required=%h at cycle %0d", act, e.sig, cyc);
                end
            end
        end
    end

    // Present a request and wait (bounded) for acceptance; leaves req_valid high.
    task automatic send(input logic [1:0] op, input logic [35:0] addr,
                        input logic ch, input logic [2:0] bg, input logic [1:0] bank,
                        input logic [15:0] row, input logic [9:0] col,
                        input bit abort, output int unsigned a);
        int unsigned n = 0;
        logic        wr;
        req_valid = 1'b1;
        req_op    = op;
        req_addr  = addr;
        while (!req_ready && n < 2000) begin
            @(negedge clk);
            n++;
        end
        a = cyc;
        chk("accept_timeout", 40'(req_ready), 40'd1);
        if (!req_ready) begin
            req_valid = 1'b0;
            return;
        end
        wr = (op == 2'd1);
        if (op == 2'd3) begin
            push_ev(a + 1, pack(2'd2, 3'd0, 1'b0, 3'd0, 2'd0, 16'd0, 10'd0, 1'b0, 1'b1));
        end else begin
            push_ev(a + 1,  pack(2'd0, 3'd0, ch, bg, bank, row, col, 1'b1, 1'b0));
            push_ev(a + 3,  pack(2'd0, 3'd1, ch, bg, bank, row, col, 1'b1, 1'b0));
            push_ev(a + 81, pack(2'd0, wr ? 3'd4 : 3'd2, ch, bg, bank, row, col, 1'b1, 1'b0));
            push_ev(a + 83, pack(2'd0, wr ? 3'd5 : 3'd3, ch, bg, bank, row, col, 1'b1, 1'b0));
            if (!abort) begin
                push_ev(a + (wr ? 235 : 179), pack(2'd0, 3'd6, ch, bg, bank, row, col, 1'b1, 1'b0));
                push_ev(a + (wr ? 313 : 257),
                        pack(2'd1, 3'd0, 1'b0, 3'd0, 2'd0, 16'd0, 10'd0, 1'b0, 1'b1));
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int unsigned n = 0;
        while (busy && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk("idle_timeout", 40'(busy), 40'd0);
        @(negedge clk);
    endtask

    initial begin
        int unsigned a1;
        int unsigned a2;

        // Reset with a request pending: nothing accepted, outputs quiet.
        req_valid = 1'b1;
        req_addr  = 36'h0_0004_09FC;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", 40'(req_ready), 40'd0);
        chk("rst_busy", 40'(busy), 40'd0);
        chk("rst_outs", 40'({cmd_valid, done, err, cmd_row}), 40'd0);
        rst       = 1'b0;
        req_valid = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", 40'(req_ready), 40'd1);
        chk("post_rst_fields", 40'({cmd_channel, cmd_bg, cmd_bank, cmd_row, cmd_col}), 40'd0);

        // Read
        send(2'd0, 36'h0_0004_09FC, 1'b1, 3'd3, 2'd2, 16'h0001, 10'h00F, 1'b0, a1);
        req_valid = 1'b0;
        wait_idle();

        // Write, same address
        send(2'd1, 36'h0_0004_09FC, 1'b1, 3'd3, 2'd2, 16'h0001, 10'h00F, 1'b0, a1);
        req_valid = 1'b0;
        wait_idle();

        // Instruction fetch: read stream
        send(2'd2, 36'h0_FFFF_FFFF, 1'b1, 3'd7, 2'd3, 16'h3FFF, 10'h3FF, 1'b0, a1);
        req_valid = 1'b0;
        wait_idle();

        // Back-to-back with req_valid held
        send(2'd0, 36'h3_0000_3000, 1'b0, 3'd0, 2'd0, 16'hC000, 10'h030, 1'b0, a1);
        send(2'd1, 36'h0_0000_0C80, 1'b0, 3'd1, 2'd3, 16'h0000, 10'h000, 1'b0, a2);
        req_valid = 1'b0;
        chk("b2b_accept_cycle", 40'(a2), 40'(a1 + 257));
        wait_idle();

        // Illegal op
        send(2'd3, 36'h0_0004_09FC, 1'b0, 3'd0, 2'd0, 16'd0, 10'd0, 1'b0, a1);
        req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("illegal_ready", 40'(req_ready), 40'd1);
        chk("illegal_busy", 40'(busy), 40'd0);

        // Reset in WAIT_PRE, with a request presented during reset
        send(2'd0, 36'h0_0004_09FC, 1'b1, 3'd3, 2'd2, 16'h0001, 10'h00F, 1'b1, a1);
        req_valid = 1'b0;
        while (cyc < a1 + 100) @(negedge clk);
        rst       = 1'b1;
        req_valid = 1'b1;
        #1;
        chk("midrst_ready", 40'(req_ready), 40'd0);
        @(posedge clk);
        #1;
        chk("midrst_busy", 40'(busy), 40'd0);
        chk("midrst_outs", 40'({cmd_valid, cmd_channel, cmd_bg, cmd_bank, cmd_row, cmd_col}), 40'd0);
        @(negedge clk);
        rst       = 1'b0;
        req_valid = 1'b0;
        repeat (200) @(negedge clk);
        chk("midrst_stays_idle", 40'({busy, req_ready}), 40'b01);

        // Recovery after abort
        send(2'd0, 36'h0_0000_0C80, 1'b0, 3'd1, 2'd3, 16'h0000, 10'h000, 1'b0, a1);
        req_valid = 1'b0;
        wait_idle();

        repeat (4) @(negedge clk);
        chk("all_events_seen", 40'(exp_q.size()), 40'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
